// File: rtl/trace_pack_pkg.sv
// Shared constants for the trace word packer: register map, CTRL bit layout, sizing helpers.
// No logic; pure compile-time definitions.
// Imported by the packer top.
package trace_pack_pkg;

  // Default register map (byte addresses on the control port)
  localparam int DEF_REGADDR_CTRL    = 'h10;
  localparam int DEF_REGADDR_TIMEOUT = 'h14;
  localparam int DEF_REGADDR_DROPCNT = 'h18;
  localparam int DEF_REGADDR_WORDCNT = 'h1C;

  // CTRL register layout
  localparam int CTRL_ENABLE_BIT = 0;
  localparam int CTRL_DROP_BIT   = 1;
  localparam int CTRL_FLUSH_BIT  = 2;
  localparam int CTRL_SLOT_LSB   = 4;
  localparam int CTRL_SLOT_W     = 4;
  localparam int CTRL_CNT_LSB    = 8;
  localparam int CTRL_CNT_W      = 8;

  // Width of the lane index; never zero so a RATIO of 1 still gets a legal vector
  function automatic int slot_width(input int ratio);
    return (ratio > 1) ? $clog2(ratio) : 1;
  endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through FIFO: head word is always visible on data_o while not empty.
// Latency: a push is visible on data_o/!empty_o the cycle after the write edge.
// Backpressure: push ignored when full unless a pop happens in the same cycle.
module sync_fifo_fwft #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_pop  = pop_i && !empty_o;
  // A pop in the same cycle frees the slot, so push-while-full is legal then
  assign do_push = push_i && (!full_o || do_pop);
  assign data_o  = mem_q[rptr_q];
  assign count_o = count_q;

  // Pointer and occupancy tracking
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage array; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= data_i;
  end

endmodule

// File: rtl/trace_word_packer.sv
// Packs IN_WIDTH trace records into DATA_WIDTH words, buffers them in a FWFT FIFO, flushes partials on request/timeout.
// Latency: completing record or flush pushes at the clock edge; ovalid rises the next cycle when the FIFO was empty.
// Backpressure: in_ready drops when the FIFO is full, unless drop mode is on (records are then discarded and counted).
module trace_word_packer
  import trace_pack_pkg::*;
#(
  parameter int IN_WIDTH        = 16,
  parameter int DATA_WIDTH      = 64,
  parameter int FIFO_DEPTH      = 8,
  parameter int CTRL_ADDR_WIDTH = 16,
  parameter logic [CTRL_ADDR_WIDTH-1:0] REGADDR_CTRL    = CTRL_ADDR_WIDTH'(DEF_REGADDR_CTRL),
  parameter logic [CTRL_ADDR_WIDTH-1:0] REGADDR_TIMEOUT = CTRL_ADDR_WIDTH'(DEF_REGADDR_TIMEOUT),
  parameter logic [CTRL_ADDR_WIDTH-1:0] REGADDR_DROPCNT = CTRL_ADDR_WIDTH'(DEF_REGADDR_DROPCNT),
  parameter logic [CTRL_ADDR_WIDTH-1:0] REGADDR_WORDCNT = CTRL_ADDR_WIDTH'(DEF_REGADDR_WORDCNT)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ctrl_wen,
  input  logic [CTRL_ADDR_WIDTH-1:0] ctrl_waddr,
  input  logic [31:0]                ctrl_wdata,
  input  logic                       ctrl_ren,
  input  logic [CTRL_ADDR_WIDTH-1:0] ctrl_raddr,
  output logic [31:0]                ctrl_rdata,
  input  logic                       in_valid,
  input  logic [IN_WIDTH-1:0]        in_data,
  output logic                       in_ready,
  output logic                       ovalid,
  output logic [DATA_WIDTH-1:0]      odata,
  input  logic                       oready
);

  localparam int RATIO  = DATA_WIDTH / IN_WIDTH;
  localparam int SLOT_W = slot_width(RATIO);
  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;

  logic                  enable_q, enable_d;
  logic                  drop_en_q, drop_en_d;
  logic                  flush_pend_q, flush_pend_d;
  logic [31:0]           timeout_q, timeout_d;
  logic [31:0]           idle_q, idle_d;
  logic [31:0]           dropcnt_q, dropcnt_d;
  logic [31:0]           wordcnt_q, wordcnt_d;
  logic [31:0]           rdata_q, rdata_d;
  logic [SLOT_W-1:0]     slot_q, slot_d;
  logic [DATA_WIDTH-1:0] lanes_q, lanes_d, lanes_ins;

  logic                  fifo_full, fifo_empty, fifo_push;
  logic [CNT_W-1:0]      fifo_count;
  logic [DATA_WIDTH-1:0] push_word;
  logic                  accept, drop, flush_fire, slot_last, timeout_hit;
  logic                  wr_ctrl;
  logic [31:0]           ctrl_view;

  // Never looks at in_valid so the traced design sees a pure state-based ready
  assign in_ready   = enable_q && (!fifo_full || drop_en_q);
  assign ovalid     = !fifo_empty;
  assign ctrl_rdata = rdata_q;

  // Packing, flush, timeout and counter next-state
  always_comb begin
    accept      = in_valid && in_ready && !fifo_full;
    drop        = in_valid && in_ready && fifo_full;
    flush_fire  = flush_pend_q && !accept && !fifo_full;
    slot_last   = (slot_q == SLOT_W'(RATIO - 1));
    timeout_hit = (timeout_q != '0) && (idle_q == timeout_q - 32'd1) && (slot_q != '0);
    wr_ctrl     = ctrl_wen && (ctrl_waddr == REGADDR_CTRL);

    lanes_ins = lanes_q;
    lanes_ins[slot_q*IN_WIDTH +: IN_WIDTH] = in_data;

    fifo_push = (accept && slot_last) || (flush_fire && (slot_q != '0));
    push_word = accept ? lanes_ins : lanes_q;

    slot_d  = slot_q;
    lanes_d = lanes_q;
    if (accept) begin
      if (slot_last) begin
        slot_d  = '0;
        lanes_d = '0;
      end else begin
        slot_d  = slot_q + 1'b1;
        lanes_d = lanes_ins;
      end
    end else if (flush_fire) begin
      slot_d  = '0;
      lanes_d = '0;
    end

    // Clear on firing first so a fresh request in the same cycle is not lost
    flush_pend_d = flush_pend_q;
    if (flush_fire) flush_pend_d = 1'b0;
    if (timeout_hit || (wr_ctrl && ctrl_wdata[CTRL_FLUSH_BIT])) flush_pend_d = 1'b1;

    idle_d    = (accept || (slot_q == '0)) ? '0 : idle_q + 32'd1;
    dropcnt_d = (drop && (dropcnt_q != 32'hFFFF_FFFF)) ? dropcnt_q + 32'd1 : dropcnt_q;
    wordcnt_d = fifo_push ? wordcnt_q + 32'd1 : wordcnt_q;

    enable_d  = wr_ctrl ? ctrl_wdata[CTRL_ENABLE_BIT] : enable_q;
    drop_en_d = wr_ctrl ? ctrl_wdata[CTRL_DROP_BIT]   : drop_en_q;
    timeout_d = (ctrl_wen && (ctrl_waddr == REGADDR_TIMEOUT)) ? ctrl_wdata : timeout_q;
  end

  // Register readback mux; unmapped addresses read as zero
  always_comb begin
    ctrl_view = '0;
    ctrl_view[CTRL_ENABLE_BIT] = enable_q;
    ctrl_view[CTRL_DROP_BIT]   = drop_en_q;
    ctrl_view[CTRL_FLUSH_BIT]  = flush_pend_q;
    ctrl_view[CTRL_SLOT_LSB +: CTRL_SLOT_W] = CTRL_SLOT_W'(slot_q);
    ctrl_view[CTRL_CNT_LSB +: CTRL_CNT_W]   = CTRL_CNT_W'(fifo_count);

    rdata_d = rdata_q;
    if (ctrl_ren) begin
      if      (ctrl_raddr == REGADDR_CTRL)    rdata_d = ctrl_view;
      else if (ctrl_raddr == REGADDR_TIMEOUT) rdata_d = timeout_q;
      else if (ctrl_raddr == REGADDR_DROPCNT) rdata_d = dropcnt_q;
      else if (ctrl_raddr == REGADDR_WORDCNT) rdata_d = wordcnt_q;
      else                                    rdata_d = '0;
    end
  end

  // State registers; reset discards the partial word along with everything else
  always_ff @(posedge clk) begin
    if (rst) begin
      enable_q     <= 1'b0;
      drop_en_q    <= 1'b0;
      flush_pend_q <= 1'b0;
      timeout_q    <= '0;
      idle_q       <= '0;
      dropcnt_q    <= '0;
      wordcnt_q    <= '0;
      rdata_q      <= '0;
      slot_q       <= '0;
      lanes_q      <= '0;
    end else begin
      enable_q     <= enable_d;
      drop_en_q    <= drop_en_d;
      flush_pend_q <= flush_pend_d;
      timeout_q    <= timeout_d;
      idle_q       <= idle_d;
      dropcnt_q    <= dropcnt_d;
      wordcnt_q    <= wordcnt_d;
      rdata_q      <= rdata_d;
      slot_q       <= slot_d;
      lanes_q      <= lanes_d;
    end
  end

  sync_fifo_fwft #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (fifo_push),
    .data_i  (push_word),
    .pop_i   (oready),
    .data_o  (odata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

endmodule

// File: tb/tb_trace_word_packer.sv
// Directed bench for trace_word_packer: table of per-cycle vectors plus hand-written multi-cycle sequences.
module tb_trace_word_packer;

  localparam logic [15:0] A_CTRL = 16'h10;
  localparam logic [15:0] A_TO   = 16'h14;
  localparam logic [15:0] A_DROP = 16'h18;
  localparam logic [15:0] A_WORD = 16'h1C;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ctrl_wen = 1'b0;
  logic [15:0] ctrl_waddr = '0;
  logic [31:0] ctrl_wdata = '0;
  logic        ctrl_ren = 1'b0;
  logic [15:0] ctrl_raddr = '0;
  logic [31:0] ctrl_rdata;
  logic        in_valid = 1'b0;
  logic [15:0] in_data = '0;
  logic        in_ready;
  logic        ovalid;
  logic [63:0] odata;
  logic        oready = 1'b1;

  int total = 0;
  int passed = 0;

  trace_word_packer dut (
    .clk(clk), .rst(rst),
    .ctrl_wen(ctrl_wen), .ctrl_waddr(ctrl_waddr), .ctrl_wdata(ctrl_wdata),
    .ctrl_ren(ctrl_ren), .ctrl_raddr(ctrl_raddr), .ctrl_rdata(ctrl_rdata),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .ovalid(ovalid), .odata(odata), .oready(oready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wen;
    logic [15:0] waddr;
    logic [31:0] wdata;
    logic        ren;
    logic [15:0] raddr;
    logic        iv;
    logic [15:0] id;
    logic        e_ov;
    logic [63:0] e_od;
    logic        e_rchk;
    logic [31:0] e_rd;
  } vec_t;

  function automatic vec_t v(input logic wen, input logic [15:0] wa, input logic [31:0] wd,
                             input logic ren, input logic [15:0] ra,
                             input logic iv, input logic [15:0] id,
                             input logic eov, input logic [63:0] eod,
                             input logic erc, input logic [31:0] erd);
    vec_t r;
    r.wen = wen; r.waddr = wa; r.wdata = wd; r.ren = ren; r.raddr = ra;
    r.iv = iv; r.id = id; r.e_ov = eov; r.e_od = eod; r.e_rchk = erc; r.e_rd = erd;
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  // Outputs are sampled 1 time unit after the active edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [15:0] a, input logic [31:0] d);
    ctrl_wen = 1'b1; ctrl_waddr = a; ctrl_wdata = d;
    tick();
    ctrl_wen = 1'b0;
  endtask

  task automatic rd(input logic [15:0] a, output logic [31:0] d);
    ctrl_ren = 1'b1; ctrl_raddr = a;
    tick();
    ctrl_ren = 1'b0;
    d = ctrl_rdata;
  endtask

  function automatic logic [63:0] pack4(input logic [15:0] base, input int w);
    logic [15:0] r0, r1, r2, r3;
    r0 = base + 16'(4*w); r1 = r0 + 16'd1; r2 = r0 + 16'd2; r3 = r0 + 16'd3;
    return {r3, r2, r1, r0};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        tbl[16];
    logic [31:0] rv;
    logic [63:0] word;
    int          first, n_acc, n_out, low_cnt;

    // ---------------- reset state ----------------
    tick(); tick();
    chk("rst_ovalid", ovalid, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_rdata", ctrl_rdata, 0);
    rst = 1'b0;

    // ---------------- table: basic pack + software flush ----------------
    tbl[0]  = v(1, A_CTRL, 1, 0, 0,     0, 0,        0, 0, 0, 0);
    tbl[1]  = v(0, 0, 0,      0, 0,     1, 16'h1111, 0, 0, 0, 0);
    tbl[2]  = v(0, 0, 0,      0, 0,     1, 16'h2222, 0, 0, 0, 0);
    tbl[3]  = v(0, 0, 0,      0, 0,     1, 16'h3333, 0, 0, 0, 0);
    tbl[4]  = v(0, 0, 0,      0, 0,     1, 16'h4444, 1, 64'h4444_3333_2222_1111, 0, 0);
    tbl[5]  = v(0, 0, 0,      1, A_WORD, 0, 0,       0, 0, 1, 1);
    tbl[6]  = v(0, 0, 0,      0, 0,     1, 16'hAAAA, 0, 0, 0, 0);
    tbl[7]  = v(0, 0, 0,      0, 0,     1, 16'hBBBB, 0, 0, 0, 0);
    tbl[8]  = v(1, A_CTRL, 5, 0, 0,     0, 0,        0, 0, 0, 0);
    tbl[9]  = v(0, 0, 0,      0, 0,     0, 0,        1, 64'h0000_0000_BBBB_AAAA, 0, 0);
    tbl[10] = v(0, 0, 0,      1, A_CTRL, 0, 0,       0, 0, 1, 32'h0000_0101);
    tbl[11] = v(1, A_CTRL, 5, 0, 0,     0, 0,        0, 0, 0, 0);
    tbl[12] = v(0, 0, 0,      1, A_CTRL, 0, 0,       0, 0, 1, 32'h0000_0005);
    tbl[13] = v(0, 0, 0,      1, A_CTRL, 0, 0,       0, 0, 1, 32'h0000_0001);
    tbl[14] = v(0, 0, 0,      1, A_WORD, 0, 0,       0, 0, 1, 2);
    tbl[15] = v(0, 0, 0,      1, 16'h20, 0, 0,       0, 0, 1, 0);

    oready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      ctrl_wen = tbl[i].wen; ctrl_waddr = tbl[i].waddr; ctrl_wdata = tbl[i].wdata;
      ctrl_ren = tbl[i].ren; ctrl_raddr = tbl[i].raddr;
      in_valid = tbl[i].iv;  in_data = tbl[i].id;
      tick();
      chk($sformatf("tbl%0d_ovalid", i), ovalid, tbl[i].e_ov);
      if (tbl[i].e_ov) chk($sformatf("tbl%0d_odata", i), odata, tbl[i].e_od);
      if (tbl[i].e_rchk) chk($sformatf("tbl%0d_rdata", i), ctrl_rdata, tbl[i].e_rd);
    end
    ctrl_wen = 1'b0; ctrl_ren = 1'b0; in_valid = 1'b0;

    // ---------------- timeout: single record then idle ----------------
    wr(A_TO, 10);
    in_valid = 1'b1; in_data = 16'h00CD;
    tick();
    in_valid = 1'b0;
    first = 0; word = '0;
    for (int k = 1; k <= 14; k++) begin
      tick();
      if (ovalid && first == 0) begin first = k; word = odata; end
    end
    chk("timeout_no_early_push", (first >= 10) ? 1'b1 : 1'b0, 1);
    chk("timeout_push_seen", (first != 0 && first <= 11) ? 1'b1 : 1'b0, 1);
    chk("timeout_word", word, 64'h0000_0000_0000_00CD);

    // ---------------- timeout restarted by a record at cycle 9 ----------------
    in_valid = 1'b1; in_data = 16'h0011;
    tick();
    in_valid = 1'b0;
    first = 0; word = '0;
    for (int k = 1; k <= 23; k++) begin
      if (k == 9) begin in_valid = 1'b1; in_data = 16'h0022; end
      tick();
      in_valid = 1'b0;
      if (ovalid && first == 0) begin first = k; word = odata; end
    end
    chk("timeout_restart_no_push", (first >= 19) ? 1'b1 : 1'b0, 1);
    chk("timeout_restart_seen", (first != 0 && first <= 20) ? 1'b1 : 1'b0, 1);
    chk("timeout_restart_word", word, 64'h0000_0000_0022_0011);
    wr(A_TO, 0);

    // ---------------- backpressure, no drop ----------------
    oready = 1'b0;
    n_acc = 0;
    for (int c = 0; c < 40; c++) begin
      in_valid = 1'b1; in_data = 16'h1000 + 16'(n_acc);
      if (in_ready) n_acc++;
      tick();
    end
    chk("bp_accepts_before_full", n_acc, 32);
    chk("bp_in_ready_low", in_ready, 0);
    rd(A_CTRL, rv);
    chk("bp_ctrl_full", rv, 32'h0000_0801);
    oready = 1'b1;
    n_out = 0;
    for (int c = 0; c < 100 && n_out < 10; c++) begin
      in_valid = (n_acc < 40); in_data = 16'h1000 + 16'(n_acc);
      if (ovalid) begin
        chk($sformatf("bp_word%0d", n_out), odata, pack4(16'h1000, n_out));
        n_out++;
      end
      if (in_valid && in_ready) n_acc++;
      tick();
    end
    in_valid = 1'b0;
    chk("bp_words_drained", n_out, 10);
    chk("bp_all_accepted", n_acc, 40);

    // ---------------- drop mode ----------------
    wr(A_CTRL, 3);
    oready = 1'b0;
    low_cnt = 0;
    for (int c = 0; c < 40; c++) begin
      in_valid = 1'b1; in_data = 16'h2000 + 16'(c);
      if (!in_ready) low_cnt++;
      tick();
    end
    in_valid = 1'b0;
    chk("drop_in_ready_high", low_cnt, 0);
    rd(A_DROP, rv);
    chk("drop_count", rv, 8);
    rd(A_CTRL, rv);
    chk("drop_ctrl_slot_count", rv, 32'h0000_0803);
    oready = 1'b1;
    n_out = 0;
    for (int c = 0; c < 50 && n_out < 8; c++) begin
      if (ovalid) begin
        chk($sformatf("drop_word%0d", n_out), odata, pack4(16'h2000, n_out));
        n_out++;
      end
      tick();
    end
    chk("drop_words_drained", n_out, 8);
    chk("drop_fifo_empty", ovalid, 0);
    wr(A_CTRL, 1);

    // ---------------- accept/flush collision ----------------
    in_valid = 1'b1; in_data = 16'h0101;
    tick();
    in_data = 16'h0202;
    ctrl_wen = 1'b1; ctrl_waddr = A_CTRL; ctrl_wdata = 5;
    tick();
    ctrl_wen = 1'b0; in_valid = 1'b0;
    chk("coll_no_push_yet", ovalid, 0);
    tick();
    chk("coll_push_valid", ovalid, 1);
    chk("coll_word", odata, 64'h0000_0000_0202_0101);
    tick();

    // ---------------- reset mid-operation ----------------
    oready = 1'b0;
    for (int c = 0; c < 13; c++) begin
      in_valid = 1'b1; in_data = 16'h3000 + 16'(c);
      tick();
    end
    in_valid = 1'b0;
    rd(A_CTRL, rv);
    chk("pre_rst_ctrl", rv, 32'h0000_0311);
    rst = 1'b1;
    tick();
    chk("mid_rst_ovalid", ovalid, 0);
    chk("mid_rst_in_ready", in_ready, 0);
    rst = 1'b0;
    rd(A_CTRL, rv);  chk("mid_rst_ctrl", rv, 0);
    rd(A_DROP, rv);  chk("mid_rst_dropcnt", rv, 0);
    rd(A_WORD, rv);  chk("mid_rst_wordcnt", rv, 0);
    rd(A_TO, rv);    chk("mid_rst_timeout", rv, 0);
    chk("post_rst_ovalid", ovalid, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
